uart_frame_sequencer: RTL
=========================

// Module: uart_frame_sequencer
// PURPOSE
//   Frame-level controller between uart_top and the coprocessor. Counts received UART chars into
//   fixed-size frames, snapshots each full frame into the coprocessor with a one-cycle valid pulse,
//   waits for the result, and fires one tx_trigger per result with a holdoff while the frame drains.
//   Tracks overrun, spurious-result and timeout errors in sticky status flags.
// PARAMETERS
//   DBITS              8          bits per UART char
//   FRAME_BYTES        16         chars per frame; frame width W = FRAME_BYTES*DBITS
//   TX_HOLDOFF_CYCLES  200_000    clk cycles held in HOLDOFF after tx_trigger (>=1)
//   TIMEOUT_CYCLES     10_000_000 result wait limit (used only with SEQ_TIMEOUT_EN)
// PORTS
//   clk              in   1   system clock
//   rst              in   1   synchronous reset, active-high
//   rx_char_received in   1   one-cycle pulse per received char from uart_top
//   rx_out           in   W   uart_top receive frame window
//   cp_din           out  W   frame snapshot to coprocessor
//   cp_din_valid     out  1   one-cycle pulse: cp_din holds a new frame
//   cp_dout          in   W   coprocessor result
//   cp_dout_valid    in   1   one-cycle pulse: cp_dout valid
//   tx_frame         out  W   result frame to uart_top tx_in
//   tx_trigger       out  1   one-cycle pulse to uart_top tx_trigger
//   status_clr       in   1   clears sticky status flags
//   status           out  4   {busy, timeout, spurious, overrun}; busy = state != COLLECT
//   char_count       out  8   chars collected in current frame
//   frame_count      out  16  results transmitted, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: state COLLECT; all outputs, counters, flags = 0. Reset mid-operation abandons frame/result.
//   All outputs registered.
//   COLLECT: each rx_char_received increments char_count; on the pulse with char_count==FRAME_BYTES-1
//     -> char_count<=0, go ISSUE.
//   ISSUE (1 cycle): cp_din<=rx_out, cp_din_valid<=1 -> WAIT. cp_din_valid is high exactly 2 cycles
//     after the final char pulse, for 1 cycle; cp_din stable until next ISSUE.
//   WAIT: on cp_dout_valid: tx_frame<=cp_dout, tx_trigger<=1 (1 cycle), frame_count+1, load holdoff
//     counter with TX_HOLDOFF_CYCLES-1 -> HOLDOFF. cp_dout_valid in the ISSUE cycle is also accepted.
//   HOLDOFF: decrement; at 0 -> COLLECT. tx_frame stable until next accepted result.
//   rx_char_received outside COLLECT: char dropped, char_count unchanged, overrun flag set.
//   cp_dout_valid in COLLECT or HOLDOFF: ignored, spurious flag set.
//   Flags sticky until status_clr; status_clr and a new set in same cycle -> set wins.
//   char_count never exceeds FRAME_BYTES-1; frame_count wraps silently.
// CONFIGURATION
//   SEQ_TIMEOUT_EN defined: WAIT cycle counter; after TIMEOUT_CYCLES cycles without cp_dout_valid,
//     set timeout flag, no tx_trigger, -> COLLECT. cp_dout_valid on the expiry cycle wins (accepted).
//   SEQ_TIMEOUT_EN undefined: WAIT waits indefinitely; timeout flag tied 0; no counter logic.
// TESTING
//   16 char pulses, rx_out=0x00..0F pattern -> cp_din_valid one cycle, 2 clk after 16th pulse,
//     cp_din=pattern, status.busy=1.
//   cp_dout_valid with 0xA5..A5 in WAIT -> tx_trigger 1 cycle next clk, tx_frame=0xA5..A5,
//     frame_count=1, COLLECT after TX_HOLDOFF_CYCLES (use 8 in bench).
//   Char pulse during WAIT -> overrun=1, char_count stays 0; status_clr -> overrun=0;
//     status_clr with simultaneous overrun set -> overrun stays 1.
//   cp_dout_valid in COLLECT -> spurious=1, no tx_trigger, char_count preserved.
//   SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, no result -> timeout=1 after 20 WAIT cycles, state COLLECT,
//     no tx_trigger; rst asserted at char_count=7 -> all outputs 0 next cycle.
//   0x10000 frames (or force frame_count=0xFFFF) -> frame_count wraps to 0.

Source files
------------

// File: rtl/uart_frame_sequencer.sv
// Frame-level sequencer between uart_top and the coprocessor: collects chars into frames,
// issues them, relays results to the transmitter. Optional result timeout: SEQ_TIMEOUT_EN.
module uart_frame_sequencer #(
    parameter int DBITS             = 8,
    parameter int FRAME_BYTES       = 16,
    parameter int TX_HOLDOFF_CYCLES = 200_000,
    parameter int TIMEOUT_CYCLES    = 10_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_char_received,
    input  logic [FRAME_BYTES*DBITS-1:0] rx_out,
    output logic [FRAME_BYTES*DBITS-1:0] cp_din,
    output logic                         cp_din_valid,
    input  logic [FRAME_BYTES*DBITS-1:0] cp_dout,
    input  logic                         cp_dout_valid,
    output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
    output logic                         tx_trigger,
    input  logic                         status_clr,
    output logic [3:0]                   status,
    output logic [7:0]                   char_count,
    output logic [15:0]                  frame_count
);

    localparam int W      = FRAME_BYTES * DBITS;
    localparam int HOLD_W = $clog2(TX_HOLDOFF_CYCLES + 1);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] HOLDOFF = 2'd3;

    if (TX_HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_frame_sequencer: TX_HOLDOFF_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]        state_r;
    logic [7:0]        char_count_r;
    logic [15:0]       frame_count_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [W-1:0]      cp_din_r;
    logic              cp_din_valid_r;
    logic [W-1:0]      tx_frame_r;
    logic              tx_trigger_r;
    logic              overrun_r;
    logic              spurious_r;
    logic              timeout_flag_s;
    logic              wait_expired_s;
    logic              overrun_set_s;
    logic              spurious_set_s;
    logic              accept_s;
    logic              timeout_set_s;

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_r;

    // Counts consecutive WAIT cycles; restarts from zero on every entry into WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    assign wait_expired_s = (state_r == WAIT) && (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Sticky timeout flag; a new set outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_set_s | (timeout_r & ~status_clr);
        end
    end

    assign timeout_flag_s = timeout_r;
`else
    assign wait_expired_s = 1'b0;
    assign timeout_flag_s = 1'b0;
`endif

    // Classifies this cycle's input events against the current state.
    always_comb begin
        overrun_set_s  = 1'b0;
        spurious_set_s = 1'b0;
        accept_s       = 1'b0;
        timeout_set_s  = 1'b0;
        case (state_r)
            COLLECT: begin
                spurious_set_s = cp_dout_valid;
            end
            ISSUE: begin
                overrun_set_s = rx_char_received;
                accept_s      = cp_dout_valid;
            end
            WAIT: begin
                overrun_set_s = rx_char_received;
                accept_s      = cp_dout_valid;
                timeout_set_s = wait_expired_s & ~cp_dout_valid;
            end
            HOLDOFF: begin
                overrun_set_s  = rx_char_received;
                spurious_set_s = cp_dout_valid;
            end
            default: begin
                overrun_set_s  = 1'b0;
                spurious_set_s = 1'b0;
            end
        endcase
    end

    // Frame FSM with its datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= COLLECT;
            char_count_r   <= 8'd0;
            frame_count_r  <= 16'd0;
            hold_cnt_r     <= {HOLD_W{1'b0}};
            cp_din_r       <= {W{1'b0}};
            cp_din_valid_r <= 1'b0;
            tx_frame_r     <= {W{1'b0}};
            tx_trigger_r   <= 1'b0;
        end else begin
            cp_din_valid_r <= 1'b0;
            tx_trigger_r   <= 1'b0;
            if (accept_s) begin
                tx_frame_r    <= cp_dout;
                tx_trigger_r  <= 1'b1;
                frame_count_r <= frame_count_r + 16'd1;
                hold_cnt_r    <= HOLD_W'(TX_HOLDOFF_CYCLES - 1);
            end
            case (state_r)
                COLLECT: begin
                    if (rx_char_received) begin
                        if (char_count_r == 8'(FRAME_BYTES - 1)) begin
                            char_count_r <= 8'd0;
                            state_r      <= ISSUE;
                        end else begin
                            char_count_r <= char_count_r + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    cp_din_r       <= rx_out;
                    cp_din_valid_r <= 1'b1;
                    state_r        <= accept_s ? HOLDOFF : WAIT;
                end
                WAIT: begin
                    if (accept_s) begin
                        state_r <= HOLDOFF;
                    end else if (timeout_set_s) begin
                        state_r <= COLLECT;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                        state_r <= COLLECT;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                    end
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end

    // Sticky overrun and spurious-result flags; a new set outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r  <= 1'b0;
            spurious_r <= 1'b0;
        end else begin
            overrun_r  <= overrun_set_s  | (overrun_r  & ~status_clr);
            spurious_r <= spurious_set_s | (spurious_r & ~status_clr);
        end
    end

    assign cp_din       = cp_din_r;
    assign cp_din_valid = cp_din_valid_r;
    assign tx_frame     = tx_frame_r;
    assign tx_trigger   = tx_trigger_r;
    assign char_count   = char_count_r;
    assign frame_count  = frame_count_r;
    assign status       = {(state_r != COLLECT), timeout_flag_s, spurious_r, overrun_r};

endmodule
